// File: rtl/candle_pattern_sequencer.sv
// Drives single-cycle set/clear strobes into the 8-candle register until its
// feedback matches a requested lit pattern, giving up after MAX_CMDS rounds.
module candle_pattern_sequencer #(
  parameter int N_CANDLES = 8,
  parameter int MAX_CMDS  = 16,
  localparam int POS_W    = (N_CANDLES > 1) ? $clog2(N_CANDLES) : 1
) (
  input  logic                 sys_clk,
  input  logic                 clr_async_n,
  input  logic                 req_valid,
  input  logic [N_CANDLES-1:0] req_pattern,
  output logic                 req_ready,
  input  logic [N_CANDLES-1:0] candle_state,
  output logic [POS_W-1:0]     pos_to_set,
  output logic                 set_enable,
  output logic [POS_W-1:0]     pos_to_clear,
  output logic                 clear_enable,
  output logic                 busy,
  output logic                 done,
  output logic                 error
);

  localparam int CNT_W = $clog2(MAX_CMDS + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SCAN,
    ST_ISSUE,
    ST_SETTLE,
    ST_DONE
  } state_t;

  state_t               state_reg, state_next;
  logic [N_CANDLES-1:0] target_reg, target_next;
  logic [CNT_W-1:0]     cmd_cnt_reg, cmd_cnt_next;
  logic [POS_W-1:0]     set_pos_reg, set_pos_next;
  logic [POS_W-1:0]     clr_pos_reg, clr_pos_next;
  logic                 set_en_reg, set_en_next;
  logic                 clr_en_reg, clr_en_next;
  logic                 error_reg, error_next;

  logic [N_CANDLES-1:0] need_set;
  logic [N_CANDLES-1:0] need_clear;
  logic [N_CANDLES-1:0] set_onehot;
  logic [N_CANDLES-1:0] clr_onehot;
  logic [POS_W-1:0]     set_idx;
  logic [POS_W-1:0]     clr_idx;

  assign need_set   = target_reg & ~candle_state;
  assign need_clear = ~target_reg & candle_state;

  // Isolate the lowest set bit (x & -x), then binary-encode the one-hot.
  assign set_onehot = need_set & (~need_set + N_CANDLES'(1));
  assign clr_onehot = need_clear & (~need_clear + N_CANDLES'(1));

  genvar gi, gj;
  generate
    for (gi = 0; gi < POS_W; gi++) begin : g_enc
      logic [N_CANDLES-1:0] sel;
      for (gj = 0; gj < N_CANDLES; gj++) begin : g_sel
        assign sel[gj] = (((gj >> gi) & 1) != 0);
      end
      assign set_idx[gi] = |(set_onehot & sel);
      assign clr_idx[gi] = |(clr_onehot & sel);
    end
  endgenerate

  always_ff @(posedge sys_clk or negedge clr_async_n) begin
    if (!clr_async_n) begin
      state_reg   <= ST_IDLE;
      target_reg  <= '0;
      cmd_cnt_reg <= '0;
      set_pos_reg <= '0;
      clr_pos_reg <= '0;
      set_en_reg  <= 1'b0;
      clr_en_reg  <= 1'b0;
      error_reg   <= 1'b0;
    end else begin
      state_reg   <= state_next;
      target_reg  <= target_next;
      cmd_cnt_reg <= cmd_cnt_next;
      set_pos_reg <= set_pos_next;
      clr_pos_reg <= clr_pos_next;
      set_en_reg  <= set_en_next;
      clr_en_reg  <= clr_en_next;
      error_reg   <= error_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    target_next  = target_reg;
    cmd_cnt_next = cmd_cnt_reg;
    set_pos_next = set_pos_reg;
    clr_pos_next = clr_pos_reg;
    set_en_next  = 1'b0;
    clr_en_next  = 1'b0;
    error_next   = error_reg;

    case (state_reg)
      ST_IDLE: begin
        if (req_valid) begin
          target_next  = req_pattern;
          cmd_cnt_next = '0;
          error_next   = 1'b0;
          state_next   = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if ((need_set == '0) && (need_clear == '0)) begin
          error_next = 1'b0;
          state_next = ST_DONE;
        end else if (cmd_cnt_reg == CNT_W'(MAX_CMDS)) begin
          error_next = 1'b1;
          state_next = ST_DONE;
        end else begin
          set_pos_next = set_idx;
          clr_pos_next = clr_idx;
          set_en_next  = |need_set;
          clr_en_next  = |need_clear;
          state_next   = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        // Budget was checked in SCAN, so this increment cannot wrap.
        cmd_cnt_next = cmd_cnt_reg + CNT_W'(1);
        state_next   = ST_SETTLE;
      end
      ST_SETTLE: state_next = ST_SCAN;
      ST_DONE:   state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  assign req_ready    = (state_reg == ST_IDLE);
  assign busy         = (state_reg != ST_IDLE);
  assign done         = (state_reg == ST_DONE);
  assign error        = error_reg;
  assign set_enable   = set_en_reg;
  assign clear_enable = clr_en_reg;
  assign pos_to_set   = set_pos_reg;
  assign pos_to_clear = clr_pos_reg;

endmodule

// File: tb/tb_candle_pattern_sequencer.sv
// Directed bench: closed-loop candle register plus a round-plan model that
// predicts every output cycle-by-cycle from the acceptance edge.
module tb_candle_pattern_sequencer;

  localparam int N   = 8;
  localparam int MAX = 16;

  logic         sys_clk = 1'b0;
  logic         clr_async_n = 1'b0;
  logic         req_valid = 1'b0;
  logic [N-1:0] req_pattern = '0;
  logic         req_ready;
  logic [N-1:0] candle_state;
  logic [2:0]   pos_to_set;
  logic         set_enable;
  logic [2:0]   pos_to_clear;
  logic         clear_enable;
  logic         busy;
  logic         done;
  logic         error;

  candle_pattern_sequencer #(.N_CANDLES(N), .MAX_CMDS(MAX)) dut (
    .sys_clk      (sys_clk),
    .clr_async_n  (clr_async_n),
    .req_valid    (req_valid),
    .req_pattern  (req_pattern),
    .req_ready    (req_ready),
    .candle_state (candle_state),
    .pos_to_set   (pos_to_set),
    .set_enable   (set_enable),
    .pos_to_clear (pos_to_clear),
    .clear_enable (clear_enable),
    .busy         (busy),
    .done         (done),
    .error        (error)
  );

  always #5 sys_clk = ~sys_clk;

  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  // Behavioural candle register, optionally overridden by a fixed feedback value.
  logic         tie_mode = 1'b0;
  logic [N-1:0] tie_val = '0;
  logic         fb_load = 1'b1;
  logic [N-1:0] fb_load_val = '0;
  logic [N-1:0] fb_reg;

  always @(posedge sys_clk) begin
    if (fb_load)
      fb_reg <= fb_load_val;
    else
      fb_reg <= (fb_reg | (set_enable ? (N'(1) << pos_to_set) : '0))
                & ~(clear_enable ? (N'(1) << pos_to_clear) : '0);
  end

  assign candle_state = tie_mode ? tie_val : fb_reg;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Round plan for the request in flight.
  int   m_R = 0;
  bit   m_plan_err = 0;
  bit   plan_set_en [0:MAX];
  int   plan_set_pos[0:MAX];
  bit   plan_clr_en [0:MAX];
  int   plan_clr_pos[0:MAX];

  function automatic int lowest(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return 0;
  endfunction

  task automatic plan_req(input logic [N-1:0] t, input logic [N-1:0] start, input bit tied);
    logic [N-1:0] s, ns, nc;
    int r;
    s = start;
    r = 0;
    forever begin
      ns = t & ~s;
      nc = ~t & s;
      if (ns == 0 && nc == 0) begin m_plan_err = 0; break; end
      if (r == MAX) begin m_plan_err = 1; break; end
      plan_set_en[r]  = (ns != 0);
      plan_set_pos[r] = lowest(ns);
      plan_clr_en[r]  = (nc != 0);
      plan_clr_pos[r] = lowest(nc);
      if (!tied) begin
        if (ns != 0) s[plan_set_pos[r]] = 1'b1;
        if (nc != 0) s[plan_clr_pos[r]] = 1'b0;
      end
      r++;
    end
    m_R = r;
  endtask

  bit m_active = 0;
  bit m_err = 0;
  int m_j = 0;
  int acc_evt = 0, done_evt = 0;
  int acc_edge = 0, lat = 0;
  int n_set = 0, n_clr = 0;
  int obs_set[0:63];
  int obs_clr[0:63];

  // m_j counts edges since acceptance: SCAN at j=3r, ISSUE at 3r+1, DONE at 3R+1.
  initial begin
    int last, r;
    bit e_done, e_issue, e_set, e_clr;
    forever begin
      @(negedge sys_clk);
      if (!clr_async_n) begin
        m_active = 0; m_err = 0; m_j = 0;
        chk("rst_ready", req_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        chk("rst_set_en", set_enable, 0);
        chk("rst_clr_en", clear_enable, 0);
        chk("rst_pos_set", pos_to_set, 0);
        chk("rst_pos_clr", pos_to_clear, 0);
      end else begin
        last    = 3 * m_R + 1;
        e_done  = m_active && (m_j == last);
        e_issue = m_active && (m_j < last) && (m_j % 3 == 1);
        r       = m_j / 3;
        e_set   = e_issue ? plan_set_en[r] : 1'b0;
        e_clr   = e_issue ? plan_clr_en[r] : 1'b0;
        chk("ready", req_ready, !m_active);
        chk("busy", busy, m_active);
        chk("done", done, e_done);
        chk("error", error, m_err);
        chk("set_en", set_enable, e_set);
        chk("clr_en", clear_enable, e_clr);
        if (e_set) chk("set_pos", pos_to_set, plan_set_pos[r]);
        if (e_clr) chk("clr_pos", pos_to_clear, plan_clr_pos[r]);
        if (set_enable && n_set < 64) begin obs_set[n_set] = pos_to_set; n_set++; end
        if (clear_enable && n_clr < 64) begin obs_clr[n_clr] = pos_to_clear; n_clr++; end
        if (e_done) begin
          lat = cyc - acc_edge;
          done_evt++;
          $display("done: lat=%0d sets=%0d clears=%0d error=%0b", lat, n_set, n_clr, error);
        end
        if (m_active) begin
          if (m_j == 3 * m_R) m_err = m_plan_err;
          if (e_done) m_active = 0;
          else m_j++;
        end else if (req_valid) begin
          plan_req(req_pattern, candle_state, tie_mode);
          m_active = 1; m_j = 0; m_err = 0;
          acc_edge = cyc + 1;
          n_set = 0; n_clr = 0;
          acc_evt++;
        end
      end
    end
  end

  task automatic wait_acc();
    int a0, k;
    a0 = acc_evt; k = 0;
    while (acc_evt == a0 && k < 50) begin @(posedge sys_clk); k++; end
    #1;
    chk("accept_timeout", (acc_evt != a0), 1);
  endtask

  task automatic wait_done();
    int d0, k;
    d0 = done_evt; k = 0;
    while (done_evt == d0 && k < 200) begin @(negedge sys_clk); k++; end
    chk("done_timeout", (done_evt != d0), 1);
  endtask

  task automatic load_fb(input bit tied, input logic [N-1:0] tv, input logic [N-1:0] fb0);
    @(posedge sys_clk); #1;
    tie_mode = tied; tie_val = tv; fb_load = 1; fb_load_val = fb0;
    @(posedge sys_clk); #1;
    fb_load = 0;
  endtask

  task automatic run_req(input logic [N-1:0] pat, input bit tied, input logic [N-1:0] tv,
                         input logic [N-1:0] fb0, input int exp_lat, input int exp_sets,
                         input int exp_clrs, input bit exp_err);
    load_fb(tied, tv, fb0);
    req_valid = 1; req_pattern = pat;
    wait_acc();
    req_valid = 0;
    wait_done();
    chk("lat", lat, exp_lat);
    chk("n_set", n_set, exp_sets);
    chk("n_clr", n_clr, exp_clrs);
    chk("done_err", error, exp_err);
    $display("req %02h from %02h: lat=%0d sets=%0d clears=%0d err=%0b", pat, fb0, lat, n_set, n_clr, error);
  endtask

  initial begin
    repeat (3) @(posedge sys_clk);
    #1 clr_async_n = 1;

    // 00 -> FF: eight ascending sets, no clears.
    run_req(8'hFF, 0, 8'h00, 8'h00, 25, 8, 0, 0);
    for (int i = 0; i < 8; i++) chk("ff_set_order", obs_set[i], i);
    chk("ff_final", fb_reg, 8'hFF);

    // 0F -> F0: paired set/clear rounds.
    run_req(8'hF0, 0, 8'h00, 8'h0F, 13, 4, 4, 0);
    for (int i = 0; i < 4; i++) begin
      chk("pair_set", obs_set[i], 4 + i);
      chk("pair_clr", obs_clr[i], i);
    end
    chk("f0_final", fb_reg, 8'hF0);

    // Already matching.
    run_req(8'hA5, 0, 8'h00, 8'hA5, 1, 0, 0, 0);
    @(negedge sys_clk);
    chk("ready_after_done", req_ready, 1);

    // Feedback stuck at 00: budget exhausted.
    run_req(8'h01, 1, 8'h00, 8'h00, 49, 16, 0, 1);
    for (int i = 0; i < 16; i++) chk("stuck_pos", obs_set[i], 0);
    repeat (3) @(negedge sys_clk);
    chk("error_hold", error, 1);

    // Reset during ISSUE.
    begin
      int d0;
      load_fb(0, 8'h00, 8'h00);
      req_valid = 1; req_pattern = 8'hFF;
      wait_acc();
      req_valid = 0;
      d0 = done_evt;
      @(posedge sys_clk); #1;
      chk("issue_strobe", set_enable, 1);
      #2 clr_async_n = 0;
      #1;
      chk("rst_drop_set", set_enable, 0);
      chk("rst_drop_ready", req_ready, 1);
      chk("rst_drop_busy", busy, 0);
      repeat (2) @(negedge sys_clk);
      @(posedge sys_clk); #1 clr_async_n = 1;
      chk("no_done_on_reset", (done_evt == d0), 1);
      chk("rst_fb_untouched", fb_reg, 8'h00);
    end
    run_req(8'h03, 0, 8'h00, 8'h00, 7, 2, 0, 0);
    chk("post_rst_final", fb_reg, 8'h03);

    // Held req_valid with a changing pattern while busy.
    begin
      int d0, k;
      load_fb(0, 8'h00, 8'h00);
      req_valid = 1; req_pattern = 8'h3C;
      wait_acc();
      d0 = done_evt; k = 0;
      forever begin
        @(posedge sys_clk); #1;
        k++;
        if (done_evt != d0 || k > 200) break;
        req_pattern = 8'($urandom);
      end
      chk("held_first_done", (done_evt != d0), 1);
      chk("held_first_lat", lat, 13);
      chk("held_first_final", fb_reg, 8'h3C);
      req_pattern = 8'h81;
      wait_acc();
      req_valid = 0;
      wait_done();
      chk("held_second_lat", lat, 13);
      @(negedge sys_clk);
      chk("held_second_final", fb_reg, 8'h81);
    end

    repeat (3) @(posedge sys_clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/candle_pattern_sequencer.md
Name: candle_pattern_sequencer

Overview:
- Command-side initiator for the 8-candle set/clear register.
- Accepts a target lit-pattern over a valid/ready handshake.
- Compares the target against the live candle_state feedback and emits single-cycle set/clear commands until the register matches the target.
- Reports completion, or an error if the match is not reached within a command budget.
- Sits between pattern-producing logic (scripts, UI decode) and the candle state register.

Parameters:
N_CANDLES, 8, number of candle bits in the pattern and the feedback.
POS_W, $clog2(N_CANDLES), width of the position fields (derived; do not override).
MAX_CMDS, 16, maximum ISSUE cycles per request before aborting with error (must be >= 1).

Ports:
sys_clk  input  1  system clock; all logic on the rising edge
clr_async_n  input  1  asynchronous, active-low reset
req_valid  input  1  target pattern offered
req_pattern  input  N_CANDLES  target lit pattern (1 = lit)
req_ready  output  1  sequencer can accept a request
candle_state  input  N_CANDLES  live state feedback from the candle register
pos_to_set  output  POS_W  bit index to set
set_enable  output  1  set command strobe
pos_to_clear  output  POS_W  bit index to clear
clear_enable  output  1  clear command strobe
busy  output  1  request in progress
done  output  1  one-cycle completion pulse
error  output  1  valid with done; 1 = MAX_CMDS exhausted before match

Behaviour:
- Reset (clr_async_n low, asynchronous):
  - State goes to IDLE; target and cmd_cnt are cleared.
  - All outputs are 0 except req_ready, which is 1.
  - Reset mid-operation abandons the request with no done pulse; command strobes drop immediately.
- All outputs are registered or pure state decode (Moore); no combinational path from inputs to outputs.
- FSM states:
  - IDLE: req_ready=1. On req_valid && req_ready, latch req_pattern into target, clear cmd_cnt, go to SCAN. req_valid while not in IDLE is ignored; the producer must hold it.
  - SCAN: compute need_set = target & ~candle_state and need_clear = ~target & candle_state.
    - Both zero: go to DONE, error=0.
    - Otherwise, if cmd_cnt == MAX_CMDS: go to DONE, error=1.
    - Otherwise: register pos_to_set = lowest index in need_set and pos_to_clear = lowest index in need_clear; set_enable = |need_set and clear_enable = |need_clear; go to ISSUE.
  - ISSUE: strobes are high for exactly this one cycle; cmd_cnt += 1; go to SETTLE.
  - SETTLE: strobes low; one cycle for the feedback to update; go to SCAN.
  - DONE: done=1 for one cycle; error is valid this cycle and holds until the next acceptance; go to IDLE.
- busy=1 in SCAN, ISSUE, SETTLE and DONE.
- Set and clear may issue in the same ISSUE cycle. Their positions can never be equal because the need masks are disjoint.
- Priority: lowest index first, both for set and for clear.
- While a strobe is low, its position output holds its last value; no requirement is placed on that value.
- Latency, with acceptance edge A:
  - Target already matches: done is high in the cycle after edge A+1.
  - Each command round costs 3 cycles, so done follows edge A+3R+1 for R rounds.
- cmd_cnt is $clog2(MAX_CMDS+1) bits wide and never wraps; the budget check happens before issuing.
- Feedback changed by other logic between rounds is tolerated: it is re-evaluated every SCAN.

Test Plan:
- Closed loop with a behavioural set/clear register, state 8'h00, request 8'hFF:
  - set_enable pulses 8 times, positions 0..7 ascending, clear_enable never high.
  - done=1, error=0 in the cycle after edge A+25.
- State 8'h0F, request 8'hF0:
  - 4 ISSUE cycles with simultaneous set/clear pairs (4,0), (5,1), (6,2), (7,3).
  - done after edge A+13, error=0, final state 8'hF0.
- State 8'hA5, request 8'hA5:
  - No strobes; done after edge A+1, error=0.
  - req_ready=0 during busy, 1 again the cycle after done.
- Feedback tied to 8'h00, request 8'h01, MAX_CMDS=16:
  - 16 set strobes at position 0, then done=1 with error=1.
  - error stays 1 until the next acceptance.
- Assert clr_async_n low during ISSUE of an 8'h00 -> 8'hFF request:
  - Strobes drop immediately; no done; req_ready=1.
  - After release, a new request 8'h03 completes normally in 2 rounds.
- req_valid held high with changing req_pattern while busy:
  - The pattern latched at acceptance is the one used; a second request is accepted only from IDLE.
